// File: rtl/rvc_asap_pkg.sv
// Shared rvc_asap definitions: instruction constants and the fetch slot record.
package rvc_asap_pkg;

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam int          I_MEM_MSB   = 11;
  localparam int          FETCH_DEPTH = 4;

  typedef struct packed {
    logic        alloc;
    logic        filled;
    logic [31:0] pc;
    logic [31:0] instr;
  } t_fetch_slot;

endpackage

// File: rtl/rvc_asap_fetch_q.sv
// Circular queue of fetch slots: allocated at the tail in request order,
// filled in response order, freed at the head when decode accepts.
module rvc_asap_fetch_q
  import rvc_asap_pkg::*;
#(
  parameter int   DEPTH = FETCH_DEPTH,
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic              QClk,
  input  logic              RstQnt,
  input  logic              i_flush,
  input  logic              i_alloc,
  input  logic [31:0]       i_alloc_pc,
  input  logic              i_fill,
  input  logic [31:0]       i_fill_instr,
  input  logic              i_pop,
  output t_fetch_slot       o_head,
  output logic [CW-1:0]     o_occ,
  output logic [CW-1:0]     o_unfilled
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  t_fetch_slot   r_slots [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_fill;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_unfilled;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Alloc writes the free tail slot, fill the oldest unfilled one and pop the
  // filled head, so the three never target the same slot in one cycle.
  always_ff @(posedge QClk) begin
    if (RstQnt || i_flush) begin
      // NOTE: the slot array is reset in full because alloc/filled gate every
      // output; only DEPTH entries, so the reset fan-out stays small.
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_occ      <= '0;
      r_unfilled <= '0;
    end else begin
      if (i_alloc) begin
        r_slots[r_tail] <= '{alloc: 1'b1, filled: 1'b0, pc: i_alloc_pc, instr: '0};
        r_tail          <= nxt(r_tail);
      end
      if (i_fill) begin
        r_slots[r_fill].filled <= 1'b1;
        r_slots[r_fill].instr  <= i_fill_instr;
        r_fill                 <= nxt(r_fill);
      end
      if (i_pop) begin
        r_slots[r_head] <= '0;
        r_head          <= nxt(r_head);
      end
      r_occ      <= r_occ + CW'(i_alloc) - CW'(i_pop);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign o_head     = r_slots[r_head];
  assign o_occ      = r_occ;
  assign o_unfilled = r_unfilled;

endmodule

// File: rtl/rvc_asap_fetch.sv
// rvc_asap fetch stage: credit-limited sequential requests, in-order response
// matching, decode handshake, and redirect flush with stale-response dropping.
module rvc_asap_fetch
  import rvc_asap_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        QClk,
  input  logic        RstQnt,
  output logic        ImemReqValid,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPc,
  output logic        IfValid,
  output logic [31:0] IfInstr,
  output logic [31:0] IfPc,
  input  logic        IfReady
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam int SW = DW + 1;

  logic [31:0]   r_pc;
  logic [DW-1:0] r_drop_cnt;

  t_fetch_slot   w_head;
  logic [CW-1:0] w_occ;
  logic [CW-1:0] w_unfilled;
  logic [31:0]   w_inflight;
  logic          w_req_fire;
  logic          w_rsp_live;
  logic          w_drop;
  logic          w_fill;
  logic          w_pop;
  logic [SW-1:0] w_drop_sum;
  logic [SW-1:0] w_drop_next;

  // Stale responses still owed by memory hold credit until they drain.
  assign w_inflight   = 32'(w_occ) + 32'(r_drop_cnt);
  assign ImemReqValid = !RstQnt && !RedirectValid && (w_inflight < 32'(DEPTH));
  assign ImemReqAddr  = r_pc;
  assign w_req_fire   = ImemReqValid && ImemReqReady;

  assign w_rsp_live = ImemRspValid && !RstQnt && !RedirectValid;
  assign w_drop     = w_rsp_live && (r_drop_cnt != '0);
  assign w_fill     = w_rsp_live && (r_drop_cnt == '0) && (w_unfilled != '0);

  assign IfValid = !RstQnt && !RedirectValid && w_head.alloc && w_head.filled;
  assign IfInstr = IfValid ? w_head.instr : NOP;
  assign IfPc    = IfValid ? w_head.pc : 32'h0;
  assign w_pop   = IfValid && IfReady;

  // A response landing in the redirect cycle settles one outstanding request.
  assign w_drop_sum  = SW'(r_drop_cnt) + SW'(w_unfilled);
  assign w_drop_next = (ImemRspValid && (w_drop_sum != '0)) ? w_drop_sum - SW'(1) : w_drop_sum;

  always_ff @(posedge QClk) begin
    if (RstQnt) begin
      r_pc       <= RESET_PC & ~32'h3;
      r_drop_cnt <= '0;
    end else if (RedirectValid) begin
      r_pc       <= RedirectPc & ~32'h3;
      r_drop_cnt <= DW'(w_drop_next);
    end else begin
      // NOTE: state updates use non-blocking assignments so every branch sees
      // the pre-edge values, matching the combinational handshake terms.
      if (w_req_fire) r_pc       <= r_pc + 32'd4;
      if (w_drop)     r_drop_cnt <= r_drop_cnt - DW'(1);
    end
  end

  rvc_asap_fetch_q #(.DEPTH(DEPTH)) u_q (
    .QClk         (QClk),
    .RstQnt       (RstQnt),
    .i_flush      (RedirectValid),
    .i_alloc      (w_req_fire),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_instr (ImemRspData),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_occ        (w_occ),
    .o_unfilled   (w_unfilled)
  );

  a_rsp_expected: assert property (@(posedge QClk) disable iff (RstQnt)
    (ImemRspValid && (r_drop_cnt == '0)) |-> (w_unfilled != '0));

endmodule
